count_monitor: RTL and testbench
================================

# count_monitor

Downstream checker for the 3-bit lap counter's `count` output. Samples the count stream every clock and verifies it steps 0→max and wraps cleanly. Tallies completed laps and declares completion once the counter parks at max after the configured number of laps. Feeds `done`/`lap_cnt`/`step_err` to the top-level status logic.

## Interface
- `WIDTH`, 3: width of the monitored count; max = 2^WIDTH−1.
- `LAPS`, 3: max→0 wraps expected before the terminal hold.
- `HOLD_CYC`, 2: consecutive repeated-max samples (after `LAPS` laps) that signal completion; ≥1.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous restart to IDLE, same effect as reset.
- `count_in` in `WIDTH`: upstream count value, sampled every cycle.
- `lap_cnt` out `$clog2(LAPS+1)`: completed wraps, saturating at `LAPS`.
- `done` out 1: level, high in DONE.
- `done_pulse` out 1: one-cycle pulse on entry to DONE.
- `step_err` out 1: sticky illegal-step flag (only with `COUNT_MON_ERR_EN`).
- `state` out 2: current FSM state, for debug.

## Operation
- States: IDLE=0, TRACK=1, DONE=2, ERR=3.
- IDLE: wait for `count_in`==0, latch prev=0, go to TRACK. Other values are ignored.
- TRACK: classify each sample against prev.
  - inc (prev+1, prev≠max): update prev.
  - wrap (prev=max, sample=0): `lap_cnt`+1; reset hold counter.
  - repeat (sample=prev): legal stall. If prev=max and `lap_cnt`==`LAPS`, hold counter +1; otherwise no effect.
  - anything else: illegal.
- Reaching hold counter==`HOLD_CYC` moves TRACK→DONE.
- DONE: `done`=1 and `count_in` ignored; leave only via `clr` or `rst`.
- ERR: `step_err`=1 and all counters frozen; leave only via `clr` or `rst`.
- Wrap while `lap_cnt`==`LAPS` (overrun) is illegal.
- Priority within a cycle: `rst` > `clr` > sample classification.

## Timing
- Reset and `clr` values: state=IDLE, `lap_cnt`=0, `done`=0, `done_pulse`=0, `step_err`=0; prev and hold counter cleared.
- All outputs are registered, one cycle after the sample that caused them.
- The 0 sample seen in IDLE reports `state`=TRACK on the next cycle.
- `done` and `done_pulse` rise the cycle after the `HOLD_CYC`-th repeated-max sample. `done_pulse` is high for exactly one cycle.
- `step_err` rises the cycle after the illegal sample and stays high.
- `rst` asserted mid-lap clears everything immediately (asynchronously). After release, monitoring resumes in IDLE waiting for 0.
- Hold counter saturates at `HOLD_CYC`. `lap_cnt` never exceeds `LAPS`.

## Configuration
- `COUNT_MON_ERR_EN` defined: illegal steps and overrun wraps go to ERR and set `step_err`.
- Not defined:
  - ERR state and `step_err` logic are removed; `step_err` is tied 0.
  - Illegal samples resynchronise: prev takes the sample and the hold counter resets.
  - Overrun wraps are ignored.

## Structure
- `count_mon_pkg` holds:
  - the state enum (IDLE/TRACK/DONE/ERR);
  - the step-class enum (INC/WRAP/REPEAT/BAD);
  - default `WIDTH`, `LAPS` and `HOLD_CYC` constants.
- One sub-module, `count_step_check`, registers prev and outputs the step class. The FSM, lap counter and hold counter stay in `count_monitor`.

## Test plan
All scenarios use `WIDTH`=3, `LAPS`=3, `HOLD_CYC`=2.
- Nominal: 0..7 ×3 with wraps, then 7,7,7.
  - `lap_cnt` reads 1, 2, 3 the cycle after each wrap.
  - `done` rises the cycle after the second repeated 7, with a single `done_pulse`.
- Stall mid-lap: 0,1,2,2,2,3..7,0.
  - No error; `lap_cnt`=1 after the wrap.
  - `done` stays 0 because repeats are not at max with `LAPS` reached.
- Illegal step with `COUNT_MON_ERR_EN`: 0,1,2,5.
  - `step_err`=1 and `state`=ERR the cycle after 5, and stay there.
  - `clr` pulse returns to IDLE with all outputs 0.
- Illegal step without `COUNT_MON_ERR_EN`: 0,1,2,5,6,7,0.
  - `step_err` stays 0; stream resyncs at 5.
  - `lap_cnt`=1 after the wrap.
- Async reset mid-lap: `rst` low at count 4 of lap 2.
  - Outputs clear in the same cycle without a clock edge.
  - After release, samples 3,4 are ignored and IDLE waits for 0.
- Overrun with `COUNT_MON_ERR_EN`: after 3 laps, 7→0 instead of hold.
  - `step_err`=1 and `lap_cnt` stays 3.

Source files
------------

// File: rtl/count_mon_pkg.sv
// ---------------------------------------------------------------------------
// count_mon_pkg
// Shared types and default parameters for the count_monitor block.
//   mon_state_e : monitor FSM states (IDLE/TRACK/DONE/ERR), encoded 0..3
//   step_e      : classification of one count sample against the previous one
//   DEF_*       : default WIDTH / LAPS / HOLD_CYC for the monitor
// ---------------------------------------------------------------------------
package count_mon_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_LAPS     = 3;
  localparam int DEF_HOLD_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    STEP_INC    = 2'd0,
    STEP_WRAP   = 2'd1,
    STEP_REPEAT = 2'd2,
    STEP_BAD    = 2'd3
  } step_e;

endpackage

// File: rtl/count_step_check.sv
// ---------------------------------------------------------------------------
// count_step_check
// Holds the previously accepted count value and classifies the current
// sample against it (increment, wrap max->0, repeat, or illegal).
// Ports:
//   clk_i     : clock, all state on rising edge
//   rst_ni    : asynchronous active-low reset, clears prev to 0
//   clr_i     : synchronous clear of prev to 0
//   load_i    : accept sample_i as the new prev value
//   sample_i  : current count sample
//   step_o    : step class of sample_i vs prev (step_e encoding)
//   at_max_o  : prev currently equals the maximum count
// ---------------------------------------------------------------------------
module count_step_check
  import count_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [1:0]       step_o,
  output logic             at_max_o
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  logic [WIDTH-1:0] prev_q, prev_d;
  step_e            step;

  // A repeat of max is a stall, not a wrap, so the repeat test goes first.
  // The increment test excludes prev==max because prev+1 overflows to 0.
  always_comb begin
    step = STEP_BAD;
    if (sample_i == prev_q) begin
      step = STEP_REPEAT;
    end else if ((prev_q == MaxVal) && (sample_i == '0)) begin
      step = STEP_WRAP;
    end else if ((prev_q != MaxVal) && (sample_i == prev_q + 1'b1)) begin
      step = STEP_INC;
    end
  end

  always_comb begin
    prev_d = prev_q;
    if (clr_i) begin
      prev_d = '0;
    end else if (load_i) begin
      prev_d = sample_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign step_o   = step;
  assign at_max_o = (prev_q == MaxVal);

endmodule

// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor
// Watches the lap counter's count stream: checks that it steps 0..max and
// wraps cleanly, tallies completed laps and reports completion once the
// counter parks at max for HOLD_CYC repeated samples after LAPS laps.
// Ports:
//   clk_i        : clock, all logic on rising edge
//   rst_ni       : asynchronous active-low reset
//   clr_i        : synchronous restart to IDLE (same effect as reset)
//   count_in_i   : upstream count value, sampled every cycle
//   lap_cnt_o    : completed max->0 wraps, saturating at LAPS
//   done_o       : high while in DONE
//   done_pulse_o : single-cycle pulse on entry to DONE
//   step_err_o   : sticky illegal-step flag
//   state_o      : current FSM state (debug)
// Configuration macro:
//   COUNT_MON_ERR_EN : illegal steps and overrun wraps go to ERR and raise
//                      step_err_o. Undefined: step_err_o is tied low,
//                      illegal samples resynchronise and overruns are
//                      ignored.
// ---------------------------------------------------------------------------
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LAPS     = DEF_LAPS,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic [WIDTH-1:0]           count_in_i,
  output logic [$clog2(LAPS+1)-1:0]  lap_cnt_o,
  output logic                       done_o,
  output logic                       done_pulse_o,
  output logic                       step_err_o,
  output logic [1:0]                 state_o
);

  localparam int LW = $clog2(LAPS + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [LW-1:0] LapsMax  = LW'(LAPS);
  localparam logic [HW-1:0] HoldMax  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYC - 1);

  mon_state_e    state_q, state_d;
  logic [LW-1:0] lap_q, lap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pulse_q, pulse_d;

  logic          prev_load;
  logic [1:0]    step_raw;
  step_e         step;
  logic          at_max;

  count_step_check #(
    .WIDTH (WIDTH)
  ) u_step_check (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr_i),
    .load_i   (prev_load),
    .sample_i (count_in_i),
    .step_o   (step_raw),
    .at_max_o (at_max)
  );

  assign step = step_e'(step_raw);

  // Next-state logic. clr_i overrides sample classification; DONE and ERR
  // ignore samples entirely, so prev and both counters stay frozen there.
  always_comb begin
    state_d   = state_q;
    lap_d     = lap_q;
    hold_d    = hold_q;
    prev_load = 1'b0;

    if (clr_i) begin
      state_d = ST_IDLE;
      lap_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_in_i == '0) begin
            state_d   = ST_TRACK;
            prev_load = 1'b1;
          end
        end

        ST_TRACK: begin
          case (step)
            STEP_INC: begin
              prev_load = 1'b1;
            end

            STEP_WRAP: begin
              if (lap_q == LapsMax) begin
`ifdef COUNT_MON_ERR_EN
                state_d = ST_ERR;
`else
                // Overrun not counted; keep following the stream.
                prev_load = 1'b1;
                hold_d    = '0;
`endif
              end else begin
                lap_d     = lap_q + 1'b1;
                hold_d    = '0;
                prev_load = 1'b1;
              end
            end

            STEP_REPEAT: begin
              // Only a stall at max after the final lap counts toward done.
              if (at_max && (lap_q == LapsMax) && (hold_q != HoldMax)) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HoldLast) begin
                  state_d = ST_DONE;
                end
              end
            end

            default: begin
`ifdef COUNT_MON_ERR_EN
              state_d = ST_ERR;
`else
              prev_load = 1'b1;
              hold_d    = '0;
`endif
            end
          endcase
        end

        default: begin
        end
      endcase
    end
  end

  assign pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lap_q   <= '0;
      hold_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
    end
  end

  assign lap_cnt_o    = lap_q;
  assign done_o       = (state_q == ST_DONE);
  assign done_pulse_o = pulse_q;
  assign state_o      = state_q;

`ifdef COUNT_MON_ERR_EN
  assign step_err_o = (state_q == ST_ERR);
`else
  assign step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_monitor
// Self-checking bench for count_monitor (WIDTH=3, LAPS=3, HOLD_CYC=2).
// A behavioural reference model predicts the registered outputs for each
// driven sample; predictions go into a scoreboard queue and are popped and
// compared one cycle later. Honors COUNT_MON_ERR_EN like the design.
// ---------------------------------------------------------------------------
module tb_count_monitor;

  localparam int WIDTH    = 3;
  localparam int LAPS     = 3;
  localparam int HOLD_CYC = 2;
  localparam int MAXC     = 7;

`ifdef COUNT_MON_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk_i;
  logic             rst_ni;
  logic             clr_i;
  logic [WIDTH-1:0] count_in_i;
  logic [1:0]       lap_cnt_o;
  logic             done_o;
  logic             done_pulse_o;
  logic             step_err_o;
  logic [1:0]       state_o;

  typedef struct {
    int state;
    int lap;
    int done;
    int pulse;
    int err;
  } exp_t;

  exp_t sbQ[$];

  int checks = 0;
  int errors = 0;

  int mState;
  int mLap;
  int mHold;
  int mPrev;
  int mPulse;

  count_monitor #(
    .WIDTH    (WIDTH),
    .LAPS     (LAPS),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_i),
    .count_in_i   (count_in_i),
    .lap_cnt_o    (lap_cnt_o),
    .done_o       (done_o),
    .done_pulse_o (done_pulse_o),
    .step_err_o   (step_err_o),
    .state_o      (state_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState = 0;
    mLap   = 0;
    mHold  = 0;
    mPrev  = 0;
    mPulse = 0;
  endtask

  // Reference behaviour for one sampled cycle.
  task automatic modelStep(input bit clr, input int s);
    mPulse = 0;
    if (clr) begin
      modelReset();
    end else if (mState == 0) begin
      if (s == 0) begin
        mState = 1;
        mPrev  = 0;
      end
    end else if (mState == 1) begin
      if (s == mPrev) begin
        if (mPrev == MAXC && mLap == LAPS) begin
          mHold++;
          if (mHold >= HOLD_CYC) begin
            mState = 2;
            mPulse = 1;
          end
        end
      end else if (mPrev == MAXC && s == 0) begin
        if (mLap == LAPS) begin
          if (ERR_EN) mState = 3;
          else begin
            mPrev = 0;
            mHold = 0;
          end
        end else begin
          mLap++;
          mPrev = 0;
          mHold = 0;
        end
      end else if (s == mPrev + 1) begin
        mPrev = s;
      end else begin
        if (ERR_EN) mState = 3;
        else begin
          mPrev = s;
          mHold = 0;
        end
      end
    end
  endtask

  task automatic observeOutputs(input string tag);
    exp_t e;
    e = sbQ.pop_front();
    checkOutput({tag, ".state"}, 32'(state_o),      e.state);
    checkOutput({tag, ".lap"},   32'(lap_cnt_o),    e.lap);
    checkOutput({tag, ".done"},  32'(done_o),       e.done);
    checkOutput({tag, ".pulse"}, 32'(done_pulse_o), e.pulse);
    checkOutput({tag, ".err"},   32'(step_err_o),   e.err);
  endtask

  // Drive one sample on the falling edge, predict, then check after the rise.
  task automatic applyStimulus(input bit clr, input int s, input string tag);
    exp_t e;
    logic [31:0] sv;
    @(negedge clk_i);
    sv         = 32'(s);
    clr_i      = clr;
    count_in_i = sv[WIDTH-1:0];
    modelStep(clr, s);
    e.state = mState;
    e.lap   = mLap;
    e.done  = (mState == 2) ? 1 : 0;
    e.pulse = mPulse;
    e.err   = (mState == 3) ? 1 : 0;
    sbQ.push_back(e);
    @(posedge clk_i);
    #1;
    observeOutputs(tag);
  endtask

  task automatic runRange(input int lo, input int hi, input string tag);
    for (int v = lo; v <= hi; v++) applyStimulus(1'b0, v, tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".state"}, 32'(state_o),      0);
    checkOutput({tag, ".lap"},   32'(lap_cnt_o),    0);
    checkOutput({tag, ".done"},  32'(done_o),       0);
    checkOutput({tag, ".pulse"}, 32'(done_pulse_o), 0);
    checkOutput({tag, ".err"},   32'(step_err_o),   0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    clr_i      = 1'b0;
    count_in_i = '0;
    modelReset();

    #12;
    checkAllZero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Nominal: initial pass plus three wrapped laps, then park at max.
    runRange(0, MAXC, "nom");
    repeat (LAPS) runRange(0, MAXC, "nom");
    repeat (3) applyStimulus(1'b0, MAXC, "nom_hold");
    applyStimulus(1'b1, 0, "nom_clr");

    // Stall mid-lap is legal and never counts toward done.
    runRange(0, 2, "stall");
    applyStimulus(1'b0, 2, "stall");
    applyStimulus(1'b0, 2, "stall");
    runRange(3, MAXC, "stall");
    applyStimulus(1'b0, 0, "stall_wrap");
    applyStimulus(1'b1, 0, "stall_clr");

    // Illegal jump 2->5, then the rest of the lap and a wrap.
    runRange(0, 2, "bad");
    applyStimulus(1'b0, 5, "bad_jump");
    runRange(6, MAXC, "bad");
    applyStimulus(1'b0, 0, "bad_wrap");
    applyStimulus(1'b1, 3, "bad_clr");

    // Asynchronous reset in the middle of lap 2.
    runRange(0, MAXC, "arst");
    runRange(0, 4, "arst");
    #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("arst_async");
    modelReset();
    sbQ.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b0, 3, "arst_ign");
    applyStimulus(1'b0, 4, "arst_ign");
    runRange(0, 2, "arst_resume");
    applyStimulus(1'b1, 0, "arst_clr");

    // Overrun: one more wrap after the final lap instead of holding.
    runRange(0, MAXC, "ovr");
    repeat (LAPS) runRange(0, MAXC, "ovr");
    applyStimulus(1'b0, 0, "ovr_wrap");
    runRange(1, MAXC, "ovr_after");
    repeat (3) applyStimulus(1'b0, MAXC, "ovr_hold");
    applyStimulus(1'b1, 0, "ovr_clr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
